// File: rtl/prince_mask_pkg.sv
// Shared state encoding, widths and randomness slicing for the masked PRINCE input stage.
package prince_mask_pkg;
    localparam int NSHARES = 5;
    localparam int W       = 64;
    localparam int RND_W   = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RND_S = 2'd1,
        RND_K = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Randomness word idx: r0 = [63:0] ... r3 = [255:192].
    function automatic logic [W-1:0] rnd_word(input logic [RND_W-1:0] rnd, input int idx);
        return rnd[idx*W +: W];
    endfunction
endpackage

// File: rtl/prince_share_split.sv
// Registered 1-to-5 Boolean split of a 64-bit word: four shares are the random
// words, the fifth is the word XORed with all of them.
module prince_share_split
    import prince_mask_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     word,
    input  logic [RND_W-1:0] rnd,
    output logic [W-1:0]     v,
    output logic [W-1:0]     w,
    output logic [W-1:0]     x,
    output logic [W-1:0]     y,
    output logic [W-1:0]     z
);
    logic [W-1:0] masked;

    always_comb begin
        masked = word;
        for (int i = 0; i < NSHARES - 1; i++) begin
            masked = masked ^ rnd_word(rnd, i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            w <= '0;
            x <= '0;
            y <= '0;
            z <= '0;
        end else if (load) begin
            v <= masked;
            w <= rnd_word(rnd, 0);
            x <= rnd_word(rnd, 1);
            y <= rnd_word(rnd, 2);
            z <= rnd_word(rnd, 3);
        end
    end
endmodule

// File: rtl/prince_share_masker.sv
// Input-side masking unit: captures plaintext/key, fetches randomness and presents
// 5-share encodings to the round datapath. Key masking is built with PRINCE_KEY_MASK_EN.
module prince_share_masker
    import prince_mask_pkg::*;
#(
    parameter int ZERO_ON_IDLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [W-1:0]     i_data,
    input  logic [W-1:0]     i_key,
    input  logic             i_inv,
    output logic             rnd_req,
    input  logic             rnd_ack,
    input  logic [RND_W-1:0] rnd,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [W-1:0]     o_v,
    output logic [W-1:0]     o_w,
    output logic [W-1:0]     o_x,
    output logic [W-1:0]     o_y,
    output logic [W-1:0]     o_z,
    output logic [W-1:0]     o_kv,
    output logic [W-1:0]     o_kw,
    output logic [W-1:0]     o_kx,
    output logic [W-1:0]     o_ky,
    output logic [W-1:0]     o_kz,
    output logic             o_inv
);
    state_t       state;
    logic [W-1:0] data_reg;
    logic [W-1:0] key_reg;
    logic         inv_reg;
    logic [W-1:0] sv, sw, sx, sy, sz;
    logic [W-1:0] kv, kw, kx, ky, kz;
    logic         hide;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data_reg <= '0;
            key_reg  <= '0;
            inv_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    data_reg <= i_data;
                    key_reg  <= i_key;
                    inv_reg  <= i_inv;
                    state    <= RND_S;
                end
                RND_S: if (rnd_ack) begin
                    // Plain data must not linger once it has been masked.
                    data_reg <= '0;
`ifdef PRINCE_KEY_MASK_EN
                    state    <= RND_K;
`else
                    state    <= OUT;
`endif
                end
`ifdef PRINCE_KEY_MASK_EN
                RND_K: if (rnd_ack) begin
                    key_reg <= '0;
                    state   <= OUT;
                end
`endif
                OUT: if (o_ready) begin
`ifndef PRINCE_KEY_MASK_EN
                    key_reg <= '0;
`endif
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign i_ready = (state == IDLE);
    assign rnd_req = (state == RND_S) || (state == RND_K);
    assign o_valid = (state == OUT);
    assign o_inv   = inv_reg;

    prince_share_split u_data_split (
        .clk  (clk),
        .rst  (rst),
        .load (state == RND_S && rnd_ack),
        .word (data_reg),
        .rnd  (rnd),
        .v    (sv),
        .w    (sw),
        .x    (sx),
        .y    (sy),
        .z    (sz)
    );

`ifdef PRINCE_KEY_MASK_EN
    prince_share_split u_key_split (
        .clk  (clk),
        .rst  (rst),
        .load (state == RND_K && rnd_ack),
        .word (key_reg),
        .rnd  (rnd),
        .v    (kv),
        .w    (kw),
        .x    (kx),
        .y    (ky),
        .z    (kz)
    );
`else
    assign kv = key_reg;
    assign kw = '0;
    assign kx = '0;
    assign ky = '0;
    assign kz = '0;
`endif

    assign hide = (ZERO_ON_IDLE != 0) && (state != OUT);

    assign o_v  = hide ? '0 : sv;
    assign o_w  = hide ? '0 : sw;
    assign o_x  = hide ? '0 : sx;
    assign o_y  = hide ? '0 : sy;
    assign o_z  = hide ? '0 : sz;
    assign o_kv = hide ? '0 : kv;
    assign o_kw = hide ? '0 : kw;
    assign o_kx = hide ? '0 : kx;
    assign o_ky = hide ? '0 : ky;
    assign o_kz = hide ? '0 : kz;
endmodule

// File: tb/tb_prince_share_masker.sv
// Bench for prince_share_masker: directed table, reset/ack corner sequences and
// random transactions checked against a share-splitting reference model.
module tb_prince_share_masker;
`ifdef PRINCE_KEY_MASK_EN
    localparam int NREQ = 2;
`else
    localparam int NREQ = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid, i_ready, i_inv;
    logic [63:0]  i_data, i_key;
    logic         rnd_req, rnd_ack;
    logic [255:0] rnd;
    logic         o_valid, o_ready, o_inv;
    logic [63:0]  o_v, o_w, o_x, o_y, o_z;
    logic [63:0]  o_kv, o_kw, o_kx, o_ky, o_kz;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] v, w, x, y, z;
    } sh_t;

    typedef struct {
        logic [63:0]  data;
        logic [63:0]  key;
        logic         inv;
        logic [255:0] rs;
        logic [255:0] rk;
        int           dly;
        int           hold;
        sh_t          exp_d;
    } vec_t;

    vec_t tbl[4];

    prince_share_masker dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_key(i_key), .i_inv(i_inv),
        .rnd_req(rnd_req), .rnd_ack(rnd_ack), .rnd(rnd),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_v(o_v), .o_w(o_w), .o_x(o_x), .o_y(o_y), .o_z(o_z),
        .o_kv(o_kv), .o_kw(o_kw), .o_kx(o_kx), .o_ky(o_ky), .o_kz(o_kz),
        .o_inv(o_inv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Reference: shares 1..4 are the random words, share 0 makes the XOR of all equal the word.
    function automatic sh_t split_model(input logic [63:0] word, input logic [255:0] r);
        sh_t s;
        logic [63:0] acc;
        s.w = r[63:0];
        s.x = r[127:64];
        s.y = r[191:128];
        s.z = r[255:192];
        acc = word;
        for (int i = 0; i < 4; i++) acc = acc ^ r[i*64 +: 64];
        s.v = acc;
        return s;
    endfunction

    task automatic chk_outputs(input string tag, input sh_t ed, input sh_t ek, input vec_t t);
        chk({tag, " o_v"}, o_v, ed.v);
        chk({tag, " o_w"}, o_w, ed.w);
        chk({tag, " o_x"}, o_x, ed.x);
        chk({tag, " o_y"}, o_y, ed.y);
        chk({tag, " o_z"}, o_z, ed.z);
        chk({tag, " o_kv"}, o_kv, ek.v);
        chk({tag, " o_kw"}, o_kw, ek.w);
        chk({tag, " o_kx"}, o_kx, ek.x);
        chk({tag, " o_ky"}, o_ky, ek.y);
        chk({tag, " o_kz"}, o_kz, ek.z);
        chk({tag, " data_xor"}, o_v ^ o_w ^ o_x ^ o_y ^ o_z, t.data);
        chk({tag, " key_xor"}, o_kv ^ o_kw ^ o_kx ^ o_ky ^ o_kz, t.key);
        chk1({tag, " o_inv"}, o_inv, t.inv);
        chk1({tag, " i_ready_out"}, i_ready, 1'b0);
    endtask

    task automatic do_txn(input vec_t t, input string tag);
        int  cyc, nack, waited;
        sh_t ek;
`ifdef PRINCE_KEY_MASK_EN
        ek = split_model(t.key, t.rk);
`else
        ek.v = t.key; ek.w = '0; ek.x = '0; ek.y = '0; ek.z = '0;
`endif
        @(negedge clk);
        chk1({tag, " i_ready_idle"}, i_ready, 1'b1);
        i_valid = 1'b1; i_data = t.data; i_key = t.key; i_inv = t.inv; rnd_ack = 1'b0;
        @(negedge clk);
        cyc = 1; nack = 0; waited = 0;
        while (!o_valid && cyc < 200) begin
            // Extra i_valid traffic while busy must be ignored.
            i_valid = 1'b1; i_data = rand64(); i_key = rand64(); i_inv = ~t.inv;
            if (rnd_req && waited >= t.dly) begin
                rnd_ack = 1'b1;
                rnd = (nack == 0) ? t.rs : t.rk;
                nack++;
                waited = 0;
            end else begin
                rnd_ack = 1'b0;
                rnd = rand256();
                if (rnd_req) waited++;
            end
            @(negedge clk);
            cyc++;
        end
        rnd_ack = 1'b0; i_valid = 1'b0; rnd = rand256();
        chk_int({tag, " latency"}, cyc, NREQ * (t.dly + 1) + 1);
        chk_int({tag, " rnd_txns"}, nack, NREQ);
        chk_outputs(tag, t.exp_d, ek, t);
        for (int h = 0; h < t.hold; h++) begin
            o_ready = 1'b0;
            rnd_ack = 1'b1;
            @(negedge clk);
            rnd_ack = 1'b0;
            chk1({tag, " hold o_valid"}, o_valid, 1'b1);
            chk_outputs({tag, " hold"}, t.exp_d, ek, t);
        end
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        chk1({tag, " idle i_ready"}, i_ready, 1'b1);
        chk1({tag, " idle o_valid"}, o_valid, 1'b0);
        chk({tag, " idle o_v"}, o_v, 64'h0);
        chk({tag, " idle o_kv"}, o_kv, 64'h0);
    endtask

    initial begin
        vec_t rv;
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_key = '0; i_inv = 1'b0;
        rnd_ack = 1'b0; rnd = '0; o_ready = 1'b0;

        tbl[0] = '{data: 64'h0123456789ABCDEF, key: 64'h0, inv: 1'b0, rs: '0, rk: '0,
                   dly: 0, hold: 0,
                   exp_d: '{v: 64'h0123456789ABCDEF, w: 64'h0, x: 64'h0, y: 64'h0, z: 64'h0}};
        tbl[1] = '{data: 64'hFFFFFFFFFFFFFFFF, key: 64'hFEDCBA9876543210, inv: 1'b1,
                   rs: {64'd1, 64'd2, 64'd4, 64'd8},
                   rk: {64'h1111111111111111, 64'h2222222222222222, 64'h4444444444444444, 64'h8888888888888888},
                   dly: 0, hold: 0,
                   exp_d: '{v: 64'hFFFFFFFFFFFFFFF0, w: 64'd8, x: 64'd4, y: 64'd2, z: 64'd1}};
        tbl[2] = '{data: 64'h0, key: 64'hA5A5A5A5A5A5A5A5, inv: 1'b0, rs: {256{1'b1}},
                   rk: {64'hDEADBEEF00000000, 64'h0, 64'h00000000CAFEF00D, 64'h123456789ABCDEF0},
                   dly: 5, hold: 0,
                   exp_d: '{v: 64'h0, w: 64'hFFFFFFFFFFFFFFFF, x: 64'hFFFFFFFFFFFFFFFF,
                            y: 64'hFFFFFFFFFFFFFFFF, z: 64'hFFFFFFFFFFFFFFFF}};
        tbl[3] = '{data: 64'hA5A5A5A5A5A5A5A5, key: 64'hA5A5A5A5A5A5A5A5, inv: 1'b1,
                   rs: {64'h0, 64'h0, 64'h0, 64'h5A5A5A5A5A5A5A5A},
                   rk: {64'h0F0F0F0F0F0F0F0F, 64'h0, 64'hFF00FF00FF00FF00, 64'h0},
                   dly: 0, hold: 4,
                   exp_d: '{v: 64'hFFFFFFFFFFFFFFFF, w: 64'h5A5A5A5A5A5A5A5A, x: 64'h0, y: 64'h0, z: 64'h0}};

        // Reset state
        repeat (2) @(negedge clk);
        chk1("rst i_ready", i_ready, 1'b1);
        chk1("rst rnd_req", rnd_req, 1'b0);
        chk1("rst o_valid", o_valid, 1'b0);
        chk1("rst o_inv", o_inv, 1'b0);
        chk("rst o_v", o_v, 64'h0);
        chk("rst o_kv", o_kv, 64'h0);
        rst = 1'b0;

        // rnd_ack pulses in IDLE must not start anything
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rnd_ack = 1'b1; rnd = rand256();
            @(negedge clk);
            rnd_ack = 1'b0;
            chk1("idle_ack i_ready", i_ready, 1'b1);
            chk1("idle_ack rnd_req", rnd_req, 1'b0);
            chk1("idle_ack o_valid", o_valid, 1'b0);
        end

        for (int i = 0; i < 4; i++) do_txn(tbl[i], $sformatf("tbl%0d", i));

        // Reset while waiting for randomness
        @(negedge clk);
        i_valid = 1'b1; i_data = 64'h1122334455667788; i_key = 64'h99AABBCCDDEEFF00; i_inv = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        chk1("midrst rnd_req", rnd_req, 1'b1);
        chk1("midrst o_inv_before", o_inv, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk1("midrst i_ready", i_ready, 1'b1);
        chk1("midrst rnd_req_after", rnd_req, 1'b0);
        chk1("midrst o_valid", o_valid, 1'b0);
        chk1("midrst o_inv", o_inv, 1'b0);
        chk("midrst o_v", o_v, 64'h0);
        chk("midrst o_kv", o_kv, 64'h0);
        rst = 1'b0;
        rv.data = 64'h1122334455667788; rv.key = 64'h99AABBCCDDEEFF00; rv.inv = 1'b0;
        rv.rs = rand256(); rv.rk = rand256(); rv.dly = 1; rv.hold = 1;
        rv.exp_d = split_model(rv.data, rv.rs);
        do_txn(rv, "post_rst");

        // Random transactions against the model
        for (int i = 0; i < 1000; i++) begin
            rv.data = rand64(); rv.key = rand64(); rv.inv = 1'($urandom_range(0, 1));
            rv.rs = rand256(); rv.rk = rand256();
            rv.dly = int'($urandom_range(0, 2)); rv.hold = int'($urandom_range(0, 1));
            rv.exp_d = split_model(rv.data, rv.rs);
            do_txn(rv, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
